// File: rtl/instr_fetch_store_if.sv
// Bus bundle between the instruction fetch/store block and its neighbours:
// the configuration stream, the reload pulse, the counter bounds, and the
// fetch request/response pair.
//
// Handshake: a config word transfers on a rising clk edge where both
// conf_valid and conf_ready are high. Upstream keeps conf_data stable while
// conf_valid is high and not yet accepted. conf_ready does not depend on
// conf_valid. The fetch side has no backpressure: every cycle with pc_en
// high in RUN returns one instr with instr_valid one cycle later.
interface instr_fetch_store_if #(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 16
);
    logic                   conf_valid;
    logic [INSTR_WIDTH-1:0] conf_data;
    logic                   conf_ready;
    logic                   reload;
    logic                   loaded;
    logic [PC_WIDTH-1:0]    max;
    logic [PC_WIDTH-1:0]    loop;
    logic                   pc_en;
    logic [PC_WIDTH-1:0]    pc;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;

    // Upstream / counter / datapath side.
    modport master (
        output conf_valid, conf_data, reload, pc_en, pc,
        input  conf_ready, loaded, max, loop, instr_valid, instr
    );

    // The instruction store itself.
    modport slave (
        input  conf_valid, conf_data, reload, pc_en, pc,
        output conf_ready, loaded, max, loop, instr_valid, instr
    );
endinterface

// File: rtl/instr_fetch_store.sv
// Per-PE instruction store and fetch stage. A config stream delivers a
// header (max, loop) followed by max+1 instruction words; once complete the
// block reports loaded, drives the counter bounds, and returns one
// registered instruction per enabled pc value.
module instr_fetch_store #(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_store_if.slave   bus,
    output logic [1:0]           state_o
);
    localparam int DEPTH = 2 ** PC_WIDTH;

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PC_WIDTH-1:0]    wcnt_q;
    logic [PC_WIDTH-1:0]    max_q;
    logic [PC_WIDTH-1:0]    loop_q;
    logic                   loaded_q;
    logic                   instr_valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;

    // Contents are deliberately not reset; reads above max are masked.
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    logic conf_ready_d;
    logic xfer;
    logic mem_we;

    // Config port is open outside RUN and closed while reset is held.
    always_comb begin
        conf_ready_d = (state_q != ST_RUN) && !rst;
        xfer         = bus.conf_valid && conf_ready_d;
        mem_we       = xfer && (state_q == ST_LOAD) && !bus.reload;
    end

    // Instruction image write port; a reload in the same cycle drops the word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wcnt_q] <= bus.conf_data;
        end
    end

    // Load/run sequencing, counter bounds, and registered fetch response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HEADER;
            wcnt_q        <= '0;
            max_q         <= '0;
            loop_q        <= '0;
            loaded_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
        end else begin
            instr_valid_q <= 1'b0;

            // Fetch depends only on the current state; reload affects
            // what happens from the next cycle on.
            if (state_q == ST_RUN && bus.pc_en) begin
                instr_q       <= (bus.pc <= max_q) ? mem_q[bus.pc] : '0;
                instr_valid_q <= 1'b1;
            end

            if (bus.reload) begin
                // Bounds hold until the next header arrives.
                state_q  <= ST_HEADER;
                loaded_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_HEADER: begin
                        if (xfer) begin
                            max_q   <= bus.conf_data[PC_WIDTH-1:0];
                            loop_q  <= bus.conf_data[2*PC_WIDTH-1:PC_WIDTH];
                            wcnt_q  <= '0;
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (xfer) begin
                            // Compare before increment so max = DEPTH-1
                            // finishes without wcnt wrapping.
                            if (wcnt_q == max_q) begin
                                state_q  <= ST_RUN;
                                loaded_q <= 1'b1;
                            end else begin
                                wcnt_q <= wcnt_q + 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q  <= ST_HEADER;
                        loaded_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.conf_ready  = conf_ready_d;
    assign bus.loaded      = loaded_q;
    assign bus.max         = max_q;
    assign bus.loop        = loop_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_instr_fetch_store.sv
// Directed bench for instr_fetch_store: load, stalled load, gated and
// out-of-range fetch, reload mid-load, reload racing the final word, a
// full-depth program, and reset while running.
module tb_instr_fetch_store;
    localparam int PW = 4;
    localparam int IW = 16;
    localparam logic [1:0] S_HEADER = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;
    int         total = 0;
    int         bad   = 0;

    instr_fetch_store_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    instr_fetch_store #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // advance one edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one word with conf_valid high for exactly one edge
    task automatic send(input logic [IW-1:0] d);
        bus.conf_valid = 1'b1;
        bus.conf_data  = d;
        tick();
        bus.conf_valid = 1'b0;
    endtask

    task automatic fetch(input logic [PW-1:0] a, input logic [IW-1:0] exp, input string tag);
        bus.pc_en = 1'b1;
        bus.pc    = a;
        tick();
        bus.pc_en = 1'b0;
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_instr"}, 32'(bus.instr), 32'(exp));
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
    endtask

    initial begin
        bus.conf_valid = 1'b0;
        bus.conf_data  = '0;
        bus.reload     = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc         = '0;

        // reset
        tick();
        tick();
        check("rst_ready_low", 32'(bus.conf_ready), 32'd0);
        check("rst_loaded", 32'(bus.loaded), 32'd0);
        check("rst_max", 32'(bus.max), 32'd0);
        check("rst_loop", 32'(bus.loop), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_HEADER));
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.conf_ready), 32'd1);

        // basic load, full throughput
        send(16'h0003);
        check("hdr_max", 32'(bus.max), 32'd3);
        check("hdr_loop", 32'(bus.loop), 32'd0);
        check("hdr_state", 32'(state_dbg), 32'(S_LOAD));
        bus.conf_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.conf_data = 16'hA000 + 16'(i);
            tick();
            if (i == 2) check("basic_not_loaded", 32'(bus.loaded), 32'd0);
        end
        bus.conf_valid = 1'b0;
        check("basic_loaded", 32'(bus.loaded), 32'd1);
        check("basic_ready_closed", 32'(bus.conf_ready), 32'd0);
        check("basic_state", 32'(state_dbg), 32'(S_RUN));

        // back-to-back fetch
        bus.pc_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pc = 4'(i);
            tick();
            check("b2b_valid", 32'(bus.instr_valid), 32'd1);
            check("b2b_instr", 32'(bus.instr), 32'(16'hA000 + 16'(i)));
        end
        bus.pc_en = 1'b0;

        // gated fetch in RUN: two idle cycles hold instr
        bus.pc = 4'd1;
        tick();
        check("gate1_valid", 32'(bus.instr_valid), 32'd0);
        check("gate1_hold", 32'(bus.instr), 32'hA003);
        tick();
        check("gate2_valid", 32'(bus.instr_valid), 32'd0);
        check("gate2_hold", 32'(bus.instr), 32'hA003);

        // out-of-range read is masked
        fetch(4'd7, 16'h0000, "oor");

        // config port closed in RUN: offered word is ignored
        send(16'h00FF);
        check("run_closed_max", 32'(bus.max), 32'd3);
        check("run_closed_loaded", 32'(bus.loaded), 32'd1);

        // stalled config with a new image
        pulse_reload();
        check("reload_loaded", 32'(bus.loaded), 32'd0);
        check("reload_ready", 32'(bus.conf_ready), 32'd1);
        check("reload_max_hold", 32'(bus.max), 32'd3);
        send(16'h0003);
        tick();
        for (int i = 0; i < 4; i++) begin
            send(16'hC000 + 16'(i));
            if (i < 3) begin
                // pc_en during LOAD must not fetch
                bus.pc_en = 1'b1;
                bus.pc    = 4'd0;
                tick();
                bus.pc_en = 1'b0;
                check("load_gated_valid", 32'(bus.instr_valid), 32'd0);
                check("stall_not_loaded", 32'(bus.loaded), 32'd0);
            end
        end
        check("stall_loaded", 32'(bus.loaded), 32'd1);
        tick();
        check("stall_ready_closed", 32'(bus.conf_ready), 32'd0);
        for (int i = 0; i < 4; i++) fetch(4'(i), 16'hC000 + 16'(i), "stall_fetch");

        // reload mid-load
        pulse_reload();
        send(16'h0003);
        send(16'hD000);
        send(16'hD001);
        pulse_reload();
        check("midload_state", 32'(state_dbg), 32'(S_HEADER));
        send(16'h0011);
        send(16'hB000);
        check("mid_not_loaded", 32'(bus.loaded), 32'd0);
        send(16'hB001);
        check("mid_loaded", 32'(bus.loaded), 32'd1);
        check("mid_max", 32'(bus.max), 32'd1);
        check("mid_loop", 32'(bus.loop), 32'd1);
        fetch(4'd1, 16'hB001, "mid_pc1");
        fetch(4'd0, 16'hB000, "mid_pc0");
        fetch(4'd2, 16'h0000, "mid_pc2_masked");

        // reload wins over the final word
        pulse_reload();
        send(16'h0020);
        check("race_max", 32'(bus.max), 32'd0);
        check("race_loop", 32'(bus.loop), 32'd2);
        bus.reload = 1'b1;
        send(16'hE000);
        bus.reload = 1'b0;
        check("race_loaded", 32'(bus.loaded), 32'd0);
        check("race_state", 32'(state_dbg), 32'(S_HEADER));

        // full-depth program, max = 15
        send(16'h000F);
        bus.conf_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.conf_data = 16'hF000 + 16'(i * 17);
            tick();
            if (i == 14) check("full_not_loaded", 32'(bus.loaded), 32'd0);
        end
        bus.conf_valid = 1'b0;
        check("full_loaded", 32'(bus.loaded), 32'd1);
        fetch(4'd15, 16'hF0FF, "full_pc15");
        fetch(4'd0, 16'hF000, "full_pc0");
        fetch(4'd9, 16'hF099, "full_pc9");

        // reset while running, pc_en held high
        fetch(4'd3, 16'hF033, "prerst_pc3");
        rst       = 1'b1;
        bus.pc_en = 1'b1;
        bus.pc    = 4'd5;
        tick();
        bus.pc_en = 1'b0;
        check("runrst_loaded", 32'(bus.loaded), 32'd0);
        check("runrst_max", 32'(bus.max), 32'd0);
        check("runrst_loop", 32'(bus.loop), 32'd0);
        check("runrst_instr", 32'(bus.instr), 32'd0);
        check("runrst_valid", 32'(bus.instr_valid), 32'd0);
        check("runrst_state", 32'(state_dbg), 32'(S_HEADER));
        rst = 1'b0;
        #1;
        check("runrst_ready", 32'(bus.conf_ready), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
